// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared opcodes, FSM states and frame geometry for the SPI RAM initiator
package spi_ram_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL,
    S_SHIFT,
    S_WAIT,
    S_READ,
    S_GAP
  } state_e;

  localparam int CTRL_BITS = 1;
  localparam int WORD_BITS = 10;
  localparam int DATA_BITS = 8;

endpackage

// File: rtl/spi_ram_master.sv
// rtl/spi_ram_master.sv - serialises one-byte RAM commands into SPI frames and returns read bytes
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int RD_WAIT = 2
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       cmd_err,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  state_e                 state_q;
  op_e                    op_q;
  logic [WORD_BITS-1:0]   sh_q;
  logic [3:0]             cnt_q;
  logic [DATA_BITS-1:0]   rx_q;
  logic                   addr_pending_q;
  logic                   ss_n_q;
  logic                   mosi_q;
  logic                   ready_q;
  logic                   err_q;
  logic                   rsp_valid_q;
  logic [DATA_BITS-1:0]   rsp_data_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= WR_ADDR;
      sh_q           <= '0;
      cnt_q          <= '0;
      rx_q           <= '0;
      addr_pending_q <= 1'b0;
      ss_n_q         <= 1'b1;
      mosi_q         <= 1'b0;
      ready_q        <= 1'b0;
      err_q          <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
    end else begin
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (cmd_valid && ready_q) begin
            // A read-data with nothing addressed is consumed without a frame.
            if (op_e'(cmd_op) == RD_DATA && !addr_pending_q) begin
              err_q <= 1'b1;
            end else begin
              op_q    <= op_e'(cmd_op);
              sh_q    <= {cmd_op, (op_e'(cmd_op) == RD_DATA) ? 8'h00 : cmd_data};
              ready_q <= 1'b0;
              ss_n_q  <= 1'b0;
              mosi_q  <= cmd_op[1];
              state_q <= S_CTRL;
            end
          end
        end
        S_CTRL: begin
          mosi_q  <= sh_q[WORD_BITS-1];
          sh_q    <= {sh_q[WORD_BITS-2:0], 1'b0};
          cnt_q   <= 4'(WORD_BITS - 1);
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt_q == 4'd0) begin
            mosi_q <= 1'b0;
            if (op_q == RD_DATA) begin
              cnt_q   <= 4'(RD_WAIT - 1);
              state_q <= S_WAIT;
            end else begin
              ss_n_q  <= 1'b1;
              state_q <= S_GAP;
              if (op_q == RD_ADDR) addr_pending_q <= 1'b1;
            end
          end else begin
            mosi_q <= sh_q[WORD_BITS-1];
            sh_q   <= {sh_q[WORD_BITS-2:0], 1'b0};
            cnt_q  <= cnt_q - 4'd1;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            cnt_q   <= 4'(DATA_BITS - 1);
            state_q <= S_READ;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_READ: begin
          rx_q <= {rx_q[DATA_BITS-2:0], MISO};
          if (cnt_q == 4'd0) begin
            rsp_data_q     <= {rx_q[DATA_BITS-2:0], MISO};
            rsp_valid_q    <= 1'b1;
            addr_pending_q <= 1'b0;
            ss_n_q         <= 1'b1;
            state_q        <= S_GAP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_GAP: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ss_n_q  <= 1'b1;
          mosi_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign cmd_err   = err_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// tb/tb_spi_ram_master.sv - directed bench with a behavioural SPI slave/RAM model
module tb_spi_ram_master;

  localparam int RD_WAIT = 2;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_err;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  spi_ram_master #(.RD_WAIT(RD_WAIT)) dut (
    .CLK(CLK), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_err(cmd_err), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 CLK = ~CLK;

  // Bus monitor: frame lengths, gaps, pulse counts and protocol violations.
  int frames = 0, low_run = 0, high_run = 0, last_len = 0, min_gap = 1000;
  int rsp_pulses = 0, err_pulses = 0, viol = 0;
  logic [7:0] last_rsp = 8'h00;
  always @(posedge CLK) begin
    if (rst_n) begin
      if (!SS_n) begin
        if (low_run == 0 && frames > 0 && high_run < min_gap) min_gap = high_run;
        low_run++;
        high_run = 0;
        if (cmd_ready) viol++;
        if (cmd_err) viol++;
      end else begin
        if (low_run > 0) begin
          last_len = low_run;
          frames++;
          low_run = 0;
        end
        high_run++;
      end
      if (rsp_valid) begin
        rsp_pulses++;
        last_rsp = rsp_data;
        if (high_run != 1) viol++;
      end
      if (cmd_err) err_pulses++;
    end else begin
      low_run = 0;
      high_run = 0;
    end
  end

  // Slave model: ctrl bit, 10-bit word, RAM, read byte returned after RD_WAIT turnaround.
  logic [7:0] mem [256];
  logic [7:0] s_waddr = 8'h00, s_raddr = 8'h00, s_rbyte = 8'h00;
  logic [9:0] s_word = 10'h0, last_word = 10'h0;
  logic       s_ctrl = 1'b0, last_ctrl = 1'b0;
  int         s_n = 0;
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge CLK) begin
    if (!rst_n || SS_n) begin
      s_n = 0;
    end else begin
      if (s_n == 0) s_ctrl = MOSI;
      else if (s_n <= 10) s_word = {s_word[8:0], MOSI};
      if (s_n == 10) begin
        last_word = s_word;
        last_ctrl = s_ctrl;
        case (s_word[9:8])
          2'b00: s_waddr = s_word[7:0];
          2'b01: mem[s_waddr] = s_word[7:0];
          2'b10: s_raddr = s_word[7:0];
          default: s_rbyte = mem[s_raddr];
        endcase
      end
      s_n++;
    end
    #1;
    if (s_n >= 11 + RD_WAIT && s_n <= 18 + RD_WAIT) MISO = s_rbyte[18 + RD_WAIT - s_n];
    else MISO = 1'b0;
  end

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] d, input bit hold);
    int t;
    t = 0;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && t < 100) begin @(negedge CLK); t++; end
    vectors++; if (t >= 100) begin miscompares++; $display("FAIL accept_timeout: waited %0d cycles, limit 100", t); end
    @(posedge CLK); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int low_cycles);
    int t;
    t = 0;
    low_cycles = 0;
    @(negedge CLK);
    while (!cmd_ready && t < 200) begin low_cycles++; @(negedge CLK); t++; end
    vectors++; if (t >= 200) begin miscompares++; $display("FAIL idle_timeout: waited %0d cycles, limit 200", t); end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #3;
    vectors++; if (SS_n !== 1'b1) begin miscompares++; $display("FAIL rst_ss_n: got %b want 1", SS_n); end
    vectors++; if (MOSI !== 1'b0) begin miscompares++; $display("FAIL rst_mosi: got %b want 0", MOSI); end
    repeat (3) @(negedge CLK);
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
    vectors++; if (cmd_err !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_pulses: err %b rsp %b want 0 0", cmd_err, rsp_valid); end
    vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data); end
    rst_n = 1'b1;
    @(negedge CLK);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_idle_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_rd_no_addr;
    int f0, e0, r0;
    f0 = frames; e0 = err_pulses; r0 = rsp_pulses;
    send_cmd(2'b11, 8'h00, 1'b0);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL noaddr_ready: got %b want 1", cmd_ready); end
    @(negedge CLK);
    vectors++; if (cmd_err !== 1'b1 || SS_n !== 1'b1) begin miscompares++; $display("FAIL noaddr_err: err %b ss_n %b want 1 1", cmd_err, SS_n); end
    @(negedge CLK);
    vectors++; if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL noaddr_err_len: got %b want 0", cmd_err); end
    repeat (3) @(negedge CLK);
    vectors++; if (err_pulses != e0 + 1 || frames != f0 || rsp_pulses != r0) begin miscompares++; $display("FAIL noaddr_counts: err %0d frames %0d rsp %0d want %0d %0d %0d", err_pulses, frames, rsp_pulses, e0 + 1, f0, r0); end
  endtask

  task automatic test_write_addr;
    int f0, lc;
    f0 = frames;
    send_cmd(2'b00, 8'hAA, 1'b0);
    vectors++; if (SS_n !== 1'b0 || cmd_ready !== 1'b0 || MOSI !== 1'b0) begin miscompares++; $display("FAIL wa_start: ss_n %b ready %b mosi %b want 0 0 0", SS_n, cmd_ready, MOSI); end
    wait_idle(lc);
    vectors++; if (lc != 12) begin miscompares++; $display("FAIL wa_ready_low: got %0d cycles want 12", lc); end
    vectors++; if (frames != f0 + 1 || last_len != 11) begin miscompares++; $display("FAIL wa_frame: frames %0d len %0d want %0d 11", frames, last_len, f0 + 1); end
    vectors++; if (last_ctrl !== 1'b0 || last_word !== 10'h0AA) begin miscompares++; $display("FAIL wa_bits: ctrl %b word %h want 0 0aa", last_ctrl, last_word); end
  endtask

  task automatic test_write_read;
    int lc, r0;
    r0 = rsp_pulses;
    send_cmd(2'b01, 8'hF0, 1'b0); wait_idle(lc);
    vectors++; if (last_word !== 10'h1F0) begin miscompares++; $display("FAIL wd_bits: got %h want 1f0", last_word); end
    send_cmd(2'b10, 8'hAA, 1'b0); wait_idle(lc);
    vectors++; if (last_ctrl !== 1'b1 || last_word !== 10'h2AA) begin miscompares++; $display("FAIL ra_bits: ctrl %b word %h want 1 2aa", last_ctrl, last_word); end
    send_cmd(2'b11, 8'hFF, 1'b0); wait_idle(lc);
    vectors++; if (last_ctrl !== 1'b1 || last_word !== 10'h300) begin miscompares++; $display("FAIL rd_bits: ctrl %b word %h want 1 300", last_ctrl, last_word); end
    vectors++; if (last_len != 11 + RD_WAIT + 8) begin miscompares++; $display("FAIL rd_len: got %0d want %0d", last_len, 11 + RD_WAIT + 8); end
    vectors++; if (rsp_pulses != r0 + 1 || last_rsp !== 8'hF0 || rsp_data !== 8'hF0) begin miscompares++; $display("FAIL rd_rsp: pulses %0d data %h hold %h want %0d f0 f0", rsp_pulses, last_rsp, rsp_data, r0 + 1); end
    vectors++; if (viol != 0) begin miscompares++; $display("FAIL rd_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_two_addr;
    int lc, e0, f0;
    send_cmd(2'b00, 8'h64, 1'b0); wait_idle(lc);
    send_cmd(2'b01, 8'hA9, 1'b0); wait_idle(lc);
    send_cmd(2'b10, 8'h02, 1'b0); wait_idle(lc);
    send_cmd(2'b10, 8'h64, 1'b0); wait_idle(lc);
    send_cmd(2'b11, 8'h00, 1'b0); wait_idle(lc);
    vectors++; if (rsp_data !== 8'hA9) begin miscompares++; $display("FAIL two_addr_rsp: got %h want a9", rsp_data); end
    e0 = err_pulses; f0 = frames;
    send_cmd(2'b11, 8'h00, 1'b0);
    repeat (4) @(negedge CLK);
    vectors++; if (err_pulses != e0 + 1 || frames != f0) begin miscompares++; $display("FAIL two_addr_err: err %0d frames %0d want %0d %0d", err_pulses, frames, e0 + 1, f0); end
  endtask

  task automatic test_back_to_back;
    int lc, f0;
    f0 = frames;
    min_gap = 1000;
    send_cmd(2'b00, 8'h10, 1'b1);
    send_cmd(2'b01, 8'h5A, 1'b1);
    send_cmd(2'b10, 8'h10, 1'b1);
    send_cmd(2'b11, 8'h00, 1'b0);
    wait_idle(lc);
    vectors++; if (frames != f0 + 4) begin miscompares++; $display("FAIL b2b_frames: got %0d want %0d", frames, f0 + 4); end
    vectors++; if (mem[8'h10] !== 8'h5A || rsp_data !== 8'h5A) begin miscompares++; $display("FAIL b2b_data: mem %h rsp %h want 5a 5a", mem[8'h10], rsp_data); end
    vectors++; if (min_gap < 1) begin miscompares++; $display("FAIL b2b_gap: got %0d want >=1", min_gap); end
    vectors++; if (viol != 0) begin miscompares++; $display("FAIL b2b_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_reset_mid_read;
    int lc, r0, f0, e0;
    send_cmd(2'b10, 8'h64, 1'b0); wait_idle(lc);
    r0 = rsp_pulses; f0 = frames;
    send_cmd(2'b11, 8'h00, 1'b0);
    repeat (19) @(posedge CLK);
    #3 rst_n = 1'b0;
    #1;
    vectors++; if (SS_n !== 1'b1 || MOSI !== 1'b0) begin miscompares++; $display("FAIL mid_rst_async: ss_n %b mosi %b want 1 0", SS_n, MOSI); end
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    repeat (2) @(negedge CLK);
    vectors++; if (rsp_data !== 8'h00 || rsp_pulses != r0 || frames != f0) begin miscompares++; $display("FAIL mid_rst_rsp: data %h pulses %0d frames %0d want 00 %0d %0d", rsp_data, rsp_pulses, frames, r0, f0); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready: got %b want 1", cmd_ready); end
    e0 = err_pulses;
    send_cmd(2'b11, 8'h00, 1'b0);
    repeat (4) @(negedge CLK);
    vectors++; if (err_pulses != e0 + 1 || frames != f0) begin miscompares++; $display("FAIL mid_rst_pending: err %0d frames %0d want %0d %0d", err_pulses, frames, e0 + 1, f0); end
  endtask

  initial begin
    test_reset;
    test_rd_no_addr;
    test_write_addr;
    test_write_read;
    test_two_addr;
    test_back_to_back;
    test_reset_mid_read;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_ram_master.md
# spi_ram_master

SPI initiator that drives the SPI slave / single-port RAM subsystem from the system side. It accepts one-byte RAM commands (write address, write data, read address, read data) on a valid/ready interface and serialises each into an SPI frame on SS_n/MOSI. For read-data commands it shifts the returned byte in on MISO and presents it as a one-cycle response. It sits between the system controller and the SPI slave, on the same CLK.

## Interface
- RD_WAIT, 2: turnaround cycles between the last MOSI bit and the first MISO bit of a read-data frame (slave + RAM latency); legal 1..7.
- CLK  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block idle and accepts a command this cycle.
- cmd_op  input  2  00 write address, 01 write data, 10 read address, 11 read data.
- cmd_data  input  8  address/data byte; ignored for op 11 (sent as 0x00).
- cmd_err  output  1  one-cycle pulse: op 11 rejected, no read address pending.
- rsp_valid  output  1  one-cycle pulse; rsp_data valid.
- rsp_data  output  8  byte read on MISO; holds until next response.
- SS_n  output  1  slave select, active low.
- MOSI  output  1  serial data to slave, MSB first.
- MISO  input  1  serial data from slave, MSB first.

## Operation
- Reset values: SS_n=1, MOSI=0, cmd_ready=0 during reset then 1 in IDLE, cmd_err=0, rsp_valid=0, rsp_data=0x00, addr_pending=0.
- States: IDLE, CTRL, SHIFT, WAIT, READ, GAP.
- IDLE: cmd_ready=1. On cmd_valid: op 11 with addr_pending=0 -> consume command, pulse cmd_err next cycle, stay IDLE, no frame. Otherwise latch word = {cmd_op, cmd_data} and go to CTRL.
- CTRL (1 cycle): SS_n=0, MOSI=cmd_op[1] (control bit selecting write/read path in slave).
- SHIFT (10 cycles): MOSI=word[9] down to word[0]; 4-bit counter 9..0.
- After SHIFT: op 11 -> WAIT; else -> GAP.
- WAIT (RD_WAIT cycles): SS_n=0, MOSI=0.
- READ (8 cycles): SS_n=0; MISO sampled each rising edge into shift register, MSB first.
- GAP (1 cycle): SS_n=1, MOSI=0, cmd_ready=0. For op 11: rsp_data updated, rsp_valid=1 this cycle.
- addr_pending: set when a 10 frame completes; cleared when an 11 frame completes; a second 10 overwrites (stays set); 00/01 leave it unchanged.
- cmd_ready is 0 in every state except IDLE; commands held during a frame are not lost (standard valid/ready).

## Timing
- Acceptance edge = k. SS_n low from edge k+1.
- Write/read-address frame: SS_n low exactly 11 cycles (1 control + 10 data), high at edge k+12; earliest next acceptance at edge k+13.
- Read-data frame: SS_n low 11+RD_WAIT+8 cycles (21 with default); rsp_valid high for the single GAP cycle right after SS_n rises.
- MOSI changes only on rising edges while SS_n=0; slave samples the following edge.
- cmd_err: asserted the cycle after the rejecting edge, exactly one cycle, never coincident with SS_n=0.
- Reset asserted mid-frame: SS_n=1 and MOSI=0 immediately (async), partial MISO byte discarded, rsp_valid not generated, addr_pending cleared; IDLE one cycle after rst_n release.
- Simultaneous cmd_valid in GAP: ignored until IDLE.

## Structure
- Package spi_ram_pkg: op enum (WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11), state enum, frame constants (CTRL_BITS=1, WORD_BITS=10, DATA_BITS=8).
- Single module; optional sub-module spi_shift_reg (parallel-load/serial-out and serial-in/parallel-out, width-parameterised) for MOSI and MISO paths.

## Test plan
- Write address 0xAA: MOSI = 0, then 00_1010_1010; SS_n low 11 cycles; cmd_ready low from k+1 to k+12.
- Write data 0xF0 then read address 0xAA then read data; slave model returns 0xF0 -> read-data frame MOSI 1,11_0000_0000; rsp_valid one pulse, rsp_data=0xF0, SS_n low 21 cycles.
- Read data with no pending address (after reset) -> cmd_err one pulse, SS_n stays 1, rsp_valid stays 0.
- Two read addresses (0x02, 0x64) then read data with model memory[0x64]=0xA9 -> rsp_data=0xA9; a second read data without new address -> cmd_err.
- cmd_valid held continuously with four commands queued -> each accepted only in IDLE, SS_n high at least 1 cycle between frames, no command dropped.
- rst_n pulsed low at bit 5 of READ -> SS_n=1 asynchronously, rsp_valid never asserted, rsp_data remains 0x00, next read data raises cmd_err.
